// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rxd, half-bit start qualification, LSB-first data,
// optional parity, 1/2 stop bits, frames queued in a FIFO and presented as AXI-Stream.
module uart_rx #(
  parameter int unsigned BAUD_PRESCALER = 12,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned BYTE_SIZE      = 8,
  parameter int unsigned STOP_BITS      = 0,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic [26:0] s_axis_config_tdata,
  input  logic        s_axis_config_tvalid,
  output logic        s_axis_config_tready,
  output logic [8:0]  m_axis_tdata,
  output logic [1:0]  m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] rx_data_count,
  output logic        overrun,
  input  logic        rxd,
  output logic        rtsn
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH} state_t;
  state_t r_state, w_state_next;

  logic [15:0] r_presc;
  logic [2:0]  r_parity;
  logic [3:0]  r_bsize;
  logic        r_stop2, r_rx_en;

  logic        r_rxd_meta, r_rxd_s, r_rxd_prev;
  logic [15:0] r_cnt;
  logic [3:0]  r_idx;
  logic [8:0]  r_data;
  logic        r_perr, r_ferr;
  logic        r_overrun, r_rtsn;

  logic [10:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr, r_rd;

  logic        w_fall, w_strobe, w_last_data, w_last_stop;
  logic        w_cfg_fire, w_push, w_pop, w_full, w_empty;
  logic [15:0] w_cfg_presc, w_half, w_period;
  logic [3:0]  w_cfg_bsize;
  logic [AW:0] w_count, w_free;
  logic [10:0] w_head;
  logic        w_unused_cfg;

  assign w_unused_cfg = ^s_axis_config_tdata[26:25];

  assign w_fall      = r_rxd_prev & ~r_rxd_s;
  assign w_strobe    = (r_cnt == '0);
  assign w_last_data = (r_idx == r_bsize - 4'd1);
  assign w_last_stop = ~r_stop2 | r_idx[0];
  assign w_half      = (r_presc >> 1) - 16'd1;
  assign w_period    = r_presc - 16'd1;

  assign w_cfg_fire  = s_axis_config_tvalid && (r_state == S_IDLE);
  assign w_cfg_presc = (s_axis_config_tdata[15:0] < 16'd2) ? 16'd2 : s_axis_config_tdata[15:0];
  assign w_cfg_bsize = (s_axis_config_tdata[22:19] == 4'd0 || s_axis_config_tdata[22:19] > 4'd9)
                       ? 4'd8 : s_axis_config_tdata[22:19];

  assign w_count = r_wr - r_rd;
  assign w_free  = DEPTH_L - w_count;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == DEPTH_L);
  assign w_pop   = ~w_empty & m_axis_tready;
  assign w_push  = (r_state == S_PUSH) && (~w_full || w_pop);
  assign w_head  = r_mem[r_rd[AW-1:0]];

  assign s_axis_config_tready = (r_state == S_IDLE);
  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tdata  = w_empty ? '0 : w_head[8:0];
  assign m_axis_tuser  = w_empty ? '0 : w_head[10:9];
  assign rx_data_count = 32'(w_count);
  assign overrun       = r_overrun;
  assign rtsn          = r_rtsn;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (r_rx_en && w_fall) w_state_next = S_START;
      S_START:  if (w_strobe) w_state_next = r_rxd_s ? S_IDLE : S_DATA;
      S_DATA:   if (w_strobe && w_last_data)
                  w_state_next = (r_parity != 3'd0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_strobe) w_state_next = S_STOP;
      S_STOP:   if (w_strobe && w_last_stop) w_state_next = S_PUSH;
      S_PUSH:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_presc    <= 16'(BAUD_PRESCALER);
      r_parity   <= 3'(PARITY);
      r_bsize    <= 4'(BYTE_SIZE);
      r_stop2    <= (STOP_BITS != 0);
      r_rx_en    <= 1'b1;
      r_rxd_meta <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_rxd_prev <= 1'b1;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_overrun  <= 1'b0;
      r_rtsn     <= 1'b1;
      r_wr       <= '0;
      r_rd       <= '0;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_s    <= r_rxd_meta;
      // Edge history frozen during PUSH so a start edge landing there is seen in IDLE.
      if (r_state != S_PUSH) r_rxd_prev <= r_rxd_s;

      if (w_cfg_fire) begin
        r_presc  <= w_cfg_presc;
        r_parity <= s_axis_config_tdata[18:16];
        r_bsize  <= w_cfg_bsize;
        r_stop2  <= s_axis_config_tdata[23];
        r_rx_en  <= s_axis_config_tdata[24];
      end

      if (r_state == S_IDLE) r_cnt <= w_half;
      else if (w_strobe)     r_cnt <= w_period;
      else                   r_cnt <= r_cnt - 16'd1;

      case (r_state)
        S_IDLE: begin
          r_idx  <= '0;
          r_data <= '0;
        end
        S_DATA: if (w_strobe) begin
          r_data[r_idx] <= r_rxd_s;
          r_idx <= w_last_data ? 4'd0 : r_idx + 4'd1;
        end
        S_PARITY: if (w_strobe) begin
          case (r_parity)
            3'd1:    r_perr <= ^r_data ^ r_rxd_s;
            3'd2:    r_perr <= ~(^r_data ^ r_rxd_s);
            3'd3:    r_perr <= ~r_rxd_s;
            3'd4:    r_perr <= r_rxd_s;
            default: r_perr <= 1'b0;
          endcase
        end
        S_STOP: if (w_strobe) begin
          r_ferr <= r_ferr | ~r_rxd_s;
          r_idx  <= r_idx + 4'd1;
        end
        S_PUSH: begin
          r_perr <= 1'b0;
          r_ferr <= 1'b0;
        end
        default: ;
      endcase

      r_overrun <= (r_state == S_PUSH) && w_full && ~w_pop;
      r_rtsn    <= ~r_rx_en || (w_free < (AW+1)'(2));
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= {r_perr, r_ferr, r_data};
  end

endmodule
